// File: rtl/axil_pkg.sv
// axil_pkg
// Shared constants and state types for the AXI-lite register responder.
//   DATA_W      : bus data/address width (32)
//   AXIL_OKAY   : write response for a committed write
//   AXIL_ERR    : write response for status or out-of-range writes
//   wr_state_t  : write-channel FSM states
//   rd_state_t  : read-channel FSM states
package axil_pkg;

    localparam int DATA_W = 32;

    localparam logic AXIL_OKAY = 1'b0;
    localparam logic AXIL_ERR  = 1'b1;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage

// File: rtl/axil_reg_slave_if.sv
// axil_reg_slave_if
// AXI-lite bus bundle between a software master and the register responder.
//   AW channel : awaddr, awvalid, awready
//   W channel  : wdata, wvalid, wready
//   B channel  : bvalid, bresp, bready
//   AR channel : araddr, arvalid, arready
//   R channel  : rdata, rvalid, rready
// Modports: master (drives requests) and slave (drives responses).
interface axil_reg_slave_if;
    import axil_pkg::*;

    logic [DATA_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic              wvalid;
    logic              wready;
    logic              bvalid;
    logic              bresp;
    logic              bready;
    logic [DATA_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bvalid, bresp, arready, rdata, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bvalid, bresp, arready, rdata, rvalid
    );

endinterface

// File: rtl/axil_addr_dec.sv
// axil_addr_dec
// Combinational byte-address to register-word decoder.
//   addr     in  : 32-bit byte address (bits [1:0] ignored)
//   idx      out : word index, addr[IDX_W+1:2]
//   is_ctrl  out : address hits a RW control register
//   is_stat  out : address hits a RO status register
//   in_range out : upper address bits are zero and idx maps to a register
module axil_addr_dec
    import axil_pkg::*;
#(
    parameter int NUM_CTRL = 4,
    parameter int NUM_STAT = 4,
    parameter int IDX_W    = 4
) (
    input  logic [DATA_W-1:0] addr,
    output logic [IDX_W-1:0]  idx,
    output logic              is_ctrl,
    output logic              is_stat,
    output logic              in_range
);

    logic        upper_zero;
    logic [31:0] idx_ext;
    logic        unused_lsb;

    assign idx        = addr[IDX_W+1:2];
    assign idx_ext    = 32'(idx);
    // Any set bit above the index field aliases nothing, so it is out of range.
    assign upper_zero = (addr[DATA_W-1:IDX_W+2] == '0);
    assign in_range   = upper_zero && (idx_ext < 32'(NUM_CTRL + NUM_STAT));
    assign is_ctrl    = in_range && (idx_ext < 32'(NUM_CTRL));
    assign is_stat    = in_range && !is_ctrl;

    // Byte-lane bits carry no meaning for word-wide registers.
    assign unused_lsb = ^addr[1:0];

endmodule

// File: rtl/axil_reg_slave.sv
// axil_reg_slave
// AXI-lite responder exposing NUM_CTRL RW control registers followed by
// NUM_STAT RO status registers. One outstanding write, one outstanding read.
//   aclk        in  : clock
//   areset      in  : synchronous active-high reset
//   axi         -   : AXI-lite bus (slave modport of axil_reg_slave_if)
//   ctrl_o      out : control registers, register k at [32k+31:32k]
//   stat_i      in  : status inputs, sampled on the AR handshake
//   wr_pulse_o  out : (only with AXIL_REG_SLAVE_WPULSE_EN) one-cycle strobe per
//                     control register after a successful write commit
// Optional feature macro: AXIL_REG_SLAVE_WPULSE_EN
module axil_reg_slave
    import axil_pkg::*;
#(
    parameter int NUM_CTRL = 4,
    parameter int NUM_STAT = 4,
    parameter int IDX_W    = 4
) (
    input  logic                       aclk,
    input  logic                       areset,
    axil_reg_slave_if.slave            axi,
    output logic [NUM_CTRL*DATA_W-1:0] ctrl_o,
    input  logic [NUM_STAT*DATA_W-1:0] stat_i
`ifdef AXIL_REG_SLAVE_WPULSE_EN
    ,
    output logic [NUM_CTRL-1:0]        wr_pulse_o
`endif
);

    wr_state_t                  wr_state;
    rd_state_t                  rd_state;
    logic                       aw_held;
    logic                       w_held;
    logic [DATA_W-1:0]          aw_addr_q;
    logic [DATA_W-1:0]          wdata_q;
    logic                       bresp_q;
    logic [DATA_W-1:0]          rdata_q;
    logic [NUM_CTRL*DATA_W-1:0] ctrl_q;

    logic                       aw_hs;
    logic                       w_hs;
    logic                       ar_hs;
    logic                       commit;
    logic [DATA_W-1:0]          wr_addr_eff;
    logic [DATA_W-1:0]          wr_data_eff;
    logic [IDX_W-1:0]           wr_idx;
    logic                       wr_is_ctrl;
    logic                       wr_is_stat;
    logic                       wr_in_range;
    logic [IDX_W-1:0]           rd_idx;
    logic                       rd_is_ctrl;
    logic                       rd_is_stat;
    logic                       rd_in_range;
    logic [DATA_W-1:0]          rd_val;
    logic                       unused_dec;

    assign aw_hs = axi.awvalid && axi.awready;
    assign w_hs  = axi.wvalid && axi.wready;
    assign ar_hs = axi.arvalid && axi.arready;

    // A payload arriving this cycle is used directly so that AW and W landing
    // on the same edge (or the second of the pair landing) commits immediately.
    assign wr_addr_eff = aw_held ? aw_addr_q : axi.awaddr;
    assign wr_data_eff = w_held ? wdata_q : axi.wdata;
    assign commit      = (wr_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);

    axil_addr_dec #(
        .NUM_CTRL (NUM_CTRL),
        .NUM_STAT (NUM_STAT),
        .IDX_W    (IDX_W)
    ) u_wr_dec (
        .addr     (wr_addr_eff),
        .idx      (wr_idx),
        .is_ctrl  (wr_is_ctrl),
        .is_stat  (wr_is_stat),
        .in_range (wr_in_range)
    );

    axil_addr_dec #(
        .NUM_CTRL (NUM_CTRL),
        .NUM_STAT (NUM_STAT),
        .IDX_W    (IDX_W)
    ) u_rd_dec (
        .addr     (axi.araddr),
        .idx      (rd_idx),
        .is_ctrl  (rd_is_ctrl),
        .is_stat  (rd_is_stat),
        .in_range (rd_in_range)
    );

    // Only control hits are writable; every other decode result is an error.
    assign unused_dec = wr_is_stat ^ wr_in_range ^ rd_in_range;

    // Write FSM: collect AW and W independently, commit once both are present,
    // then hold the B response until the master accepts it.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_state  <= W_IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            wdata_q   <= '0;
            bresp_q   <= AXIL_OKAY;
            ctrl_q    <= '0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (commit) begin
                        aw_held  <= 1'b0;
                        w_held   <= 1'b0;
                        bresp_q  <= wr_is_ctrl ? AXIL_OKAY : AXIL_ERR;
                        wr_state <= W_RESP;
                        for (int k = 0; k < NUM_CTRL; k++) begin
                            if (wr_is_ctrl && (wr_idx == IDX_W'(k))) begin
                                ctrl_q[k*DATA_W +: DATA_W] <= wr_data_eff;
                            end
                        end
                    end else begin
                        if (aw_hs) begin
                            aw_held   <= 1'b1;
                            aw_addr_q <= axi.awaddr;
                        end
                        if (w_hs) begin
                            w_held  <= 1'b1;
                            wdata_q <= axi.wdata;
                        end
                    end
                end
                W_RESP: begin
                    if (axi.bready) begin
                        wr_state <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

`ifdef AXIL_REG_SLAVE_WPULSE_EN
    // Strobe lines up with the first bvalid cycle of a successful write.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_pulse_o <= '0;
        end else begin
            wr_pulse_o <= '0;
            if (commit && wr_is_ctrl) begin
                for (int k = 0; k < NUM_CTRL; k++) begin
                    if (wr_idx == IDX_W'(k)) begin
                        wr_pulse_o[k] <= 1'b1;
                    end
                end
            end
        end
    end
`endif

    // Read source mux; reads ctrl_q before any same-edge write lands.
    always_comb begin
        rd_val = '0;
        for (int k = 0; k < NUM_CTRL; k++) begin
            if (rd_is_ctrl && (rd_idx == IDX_W'(k))) begin
                rd_val = ctrl_q[k*DATA_W +: DATA_W];
            end
        end
        for (int j = 0; j < NUM_STAT; j++) begin
            if (rd_is_stat && (rd_idx == IDX_W'(NUM_CTRL + j))) begin
                rd_val = stat_i[j*DATA_W +: DATA_W];
            end
        end
    end

    // Read FSM: register the data on the AR handshake, hold it until rready.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rd_state <= R_IDLE;
            rdata_q  <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        rdata_q  <= rd_val;
                        rd_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (axi.rready) begin
                        rd_state <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    assign axi.awready = (wr_state == W_IDLE) && !aw_held;
    assign axi.wready  = (wr_state == W_IDLE) && !w_held;
    assign axi.bvalid  = (wr_state == W_RESP);
    assign axi.bresp   = bresp_q;
    assign axi.arready = (rd_state == R_IDLE);
    assign axi.rvalid  = (rd_state == R_DATA);
    assign axi.rdata   = rdata_q;
    assign ctrl_o      = ctrl_q;

endmodule

// File: tb/tb_axil_reg_slave.sv
// tb_axil_reg_slave
// Directed testbench for axil_reg_slave. Inputs change and outputs are
// checked on the falling clock edge, away from the sampling edge.
// Honours AXIL_REG_SLAVE_WPULSE_EN when the design is built with it.
module tb_axil_reg_slave;

    logic         aclk;
    logic         areset;
    logic [127:0] ctrl_o;
    logic [127:0] stat_i;
`ifdef AXIL_REG_SLAVE_WPULSE_EN
    logic [3:0]   wr_pulse_o;
`endif

    int vectors    = 0;
    int miscompares = 0;
    logic [127:0] expCtrl;

    axil_reg_slave_if axi ();

    axil_reg_slave dut (
        .aclk       (aclk),
        .areset     (areset),
        .axi        (axi),
        .ctrl_o     (ctrl_o),
        .stat_i     (stat_i)
`ifdef AXIL_REG_SLAVE_WPULSE_EN
        ,
        .wr_pulse_o (wr_pulse_o)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge n times.
    task automatic applyStimulus(input int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic idleBus();
        axi.awaddr  = '0;
        axi.awvalid = 1'b0;
        axi.wdata   = '0;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;
        axi.araddr  = '0;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
    endtask

    initial begin
        idleBus();
        stat_i  = '0;
        areset  = 1'b1;
        expCtrl = '0;
        applyStimulus(2);
        areset = 1'b0;

        // Reset state
        checkOutput("rst_awready", 128'(axi.awready), 128'(1));
        checkOutput("rst_wready",  128'(axi.wready),  128'(1));
        checkOutput("rst_arready", 128'(axi.arready), 128'(1));
        checkOutput("rst_bvalid",  128'(axi.bvalid),  128'(0));
        checkOutput("rst_bresp",   128'(axi.bresp),   128'(0));
        checkOutput("rst_rvalid",  128'(axi.rvalid),  128'(0));
        checkOutput("rst_rdata",   128'(axi.rdata),   128'(0));
        checkOutput("rst_ctrl",    ctrl_o,            128'(0));
`ifdef AXIL_REG_SLAVE_WPULSE_EN
        checkOutput("rst_pulse",   128'(wr_pulse_o),  128'(0));
`endif

        // AW and W together to 0x4
        axi.awaddr = 32'h4; axi.awvalid = 1'b1;
        axi.wdata = 32'hA5A5_0001; axi.wvalid = 1'b1;
        applyStimulus(1);
        expCtrl[63:32] = 32'hA5A5_0001;
        checkOutput("t1_bvalid",  128'(axi.bvalid),  128'(1));
        checkOutput("t1_bresp",   128'(axi.bresp),   128'(0));
        checkOutput("t1_ctrl",    ctrl_o,            expCtrl);
        checkOutput("t1_awready", 128'(axi.awready), 128'(0));
`ifdef AXIL_REG_SLAVE_WPULSE_EN
        checkOutput("t1_pulse",   128'(wr_pulse_o),  128'(4'b0010));
`endif
        idleBus();
        axi.bready = 1'b1;
        applyStimulus(1);
        checkOutput("t1_bdone",   128'(axi.bvalid),  128'(0));
        checkOutput("t1_awrdy2",  128'(axi.awready), 128'(1));
        idleBus();
        axi.araddr = 32'h4; axi.arvalid = 1'b1;
        applyStimulus(1);
        checkOutput("t1_rvalid",  128'(axi.rvalid),  128'(1));
        checkOutput("t1_rdata",   128'(axi.rdata),   128'(32'hA5A5_0001));
        checkOutput("t1_arready", 128'(axi.arready), 128'(0));
        idleBus();
        axi.rready = 1'b1;
        applyStimulus(1);
        checkOutput("t1_rdone",   128'(axi.rvalid),  128'(0));
        idleBus();

        // W three cycles ahead of AW to 0x8
        axi.wdata = 32'h5A5A_0002; axi.wvalid = 1'b1;
        applyStimulus(1);
        axi.wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("t2_wready_low", 128'(axi.wready),  128'(0));
            checkOutput("t2_awready_hi", 128'(axi.awready), 128'(1));
            checkOutput("t2_no_bvalid",  128'(axi.bvalid),  128'(0));
            checkOutput("t2_ctrl_hold",  ctrl_o,            expCtrl);
            if (i < 2) applyStimulus(1);
        end
        axi.awaddr = 32'h8; axi.awvalid = 1'b1;
        applyStimulus(1);
        expCtrl[95:64] = 32'h5A5A_0002;
        checkOutput("t2_bvalid", 128'(axi.bvalid), 128'(1));
        checkOutput("t2_bresp",  128'(axi.bresp),  128'(0));
        checkOutput("t2_ctrl",   ctrl_o,           expCtrl);
        idleBus();
        axi.bready = 1'b1;
        applyStimulus(1);
        idleBus();

        // Status write (0x10), out-of-range writes (0x40, 0x8000_0000)
        axi.awaddr = 32'h10; axi.awvalid = 1'b1;
        axi.wdata = 32'hDEAD_BEEF; axi.wvalid = 1'b1;
        applyStimulus(1);
        checkOutput("t3_stat_bvalid", 128'(axi.bvalid), 128'(1));
        checkOutput("t3_stat_bresp",  128'(axi.bresp),  128'(1));
        checkOutput("t3_stat_ctrl",   ctrl_o,           expCtrl);
`ifdef AXIL_REG_SLAVE_WPULSE_EN
        checkOutput("t3_stat_pulse",  128'(wr_pulse_o), 128'(0));
`endif
        idleBus();
        axi.bready = 1'b1;
        applyStimulus(1);
        idleBus();
        axi.awaddr = 32'h40; axi.awvalid = 1'b1;
        axi.wdata = 32'hDEAD_BEEF; axi.wvalid = 1'b1;
        applyStimulus(1);
        checkOutput("t3_oor_bresp", 128'(axi.bresp), 128'(1));
        checkOutput("t3_oor_ctrl",  ctrl_o,          expCtrl);
        idleBus();
        axi.bready = 1'b1;
        applyStimulus(1);
        idleBus();
        axi.awaddr = 32'h8000_0000; axi.awvalid = 1'b1;
        axi.wdata = 32'hDEAD_BEEF; axi.wvalid = 1'b1;
        applyStimulus(1);
        checkOutput("t3_hi_bresp", 128'(axi.bresp), 128'(1));
        checkOutput("t3_hi_ctrl",  ctrl_o,          expCtrl);
        idleBus();
        axi.bready = 1'b1;
        applyStimulus(1);
        idleBus();
        axi.araddr = 32'h40; axi.arvalid = 1'b1;
        applyStimulus(1);
        checkOutput("t3_oor_rvalid", 128'(axi.rvalid), 128'(1));
        checkOutput("t3_oor_rdata",  128'(axi.rdata),  128'(0));
        idleBus();
        axi.rready = 1'b1;
        applyStimulus(1);
        idleBus();

        // Status read with back-pressure
        stat_i[31:0] = 32'h1234_5678;
        axi.araddr = 32'h10; axi.arvalid = 1'b1;
        applyStimulus(1);
        axi.arvalid = 1'b0;
        stat_i[31:0] = 32'h0BAD_F00D;
        for (int i = 0; i < 4; i++) begin
            checkOutput("t4_rvalid",  128'(axi.rvalid),  128'(1));
            checkOutput("t4_rdata",   128'(axi.rdata),   128'(32'h1234_5678));
            checkOutput("t4_arready", 128'(axi.arready), 128'(0));
            applyStimulus(1);
        end
        axi.rready = 1'b1;
        applyStimulus(1);
        checkOutput("t4_rdone",   128'(axi.rvalid),  128'(0));
        checkOutput("t4_arready2", 128'(axi.arready), 128'(1));
        idleBus();

        // Same-edge write and read of register 0
        axi.awaddr = 32'h0; axi.awvalid = 1'b1;
        axi.wdata = 32'hFFFF_FFFF; axi.wvalid = 1'b1;
        axi.araddr = 32'h0; axi.arvalid = 1'b1;
        applyStimulus(1);
        expCtrl[31:0] = 32'hFFFF_FFFF;
        checkOutput("t5_rdata",  128'(axi.rdata),  128'(0));
        checkOutput("t5_ctrl",   ctrl_o,           expCtrl);
        checkOutput("t5_bvalid", 128'(axi.bvalid), 128'(1));
`ifdef AXIL_REG_SLAVE_WPULSE_EN
        checkOutput("t5_pulse",  128'(wr_pulse_o), 128'(4'b0001));
`endif
        idleBus();
        axi.bready = 1'b1; axi.rready = 1'b1;
        applyStimulus(1);
        checkOutput("t5_bdone", 128'(axi.bvalid), 128'(0));
        checkOutput("t5_rdone", 128'(axi.rvalid), 128'(0));
`ifdef AXIL_REG_SLAVE_WPULSE_EN
        checkOutput("t5_pulse_off", 128'(wr_pulse_o), 128'(0));
`endif
        idleBus();

        // Reset while both responses are pending
        axi.awaddr = 32'hC; axi.awvalid = 1'b1;
        axi.wdata = 32'h1111_2222; axi.wvalid = 1'b1;
        axi.araddr = 32'h0; axi.arvalid = 1'b1;
        applyStimulus(1);
        expCtrl[127:96] = 32'h1111_2222;
        checkOutput("t6_bvalid", 128'(axi.bvalid), 128'(1));
        checkOutput("t6_rvalid", 128'(axi.rvalid), 128'(1));
        checkOutput("t6_rdata",  128'(axi.rdata),  128'(32'hFFFF_FFFF));
        checkOutput("t6_ctrl",   ctrl_o,           expCtrl);
        idleBus();
        areset = 1'b1;
        applyStimulus(1);
        areset = 1'b0;
        checkOutput("t6_rst_bvalid",  128'(axi.bvalid),  128'(0));
        checkOutput("t6_rst_rvalid",  128'(axi.rvalid),  128'(0));
        checkOutput("t6_rst_ctrl",    ctrl_o,            128'(0));
        checkOutput("t6_rst_awready", 128'(axi.awready), 128'(1));
        checkOutput("t6_rst_wready",  128'(axi.wready),  128'(1));
        checkOutput("t6_rst_arready", 128'(axi.arready), 128'(1));
        checkOutput("t6_rst_rdata",   128'(axi.rdata),   128'(0));
        axi.bready = 1'b1; axi.rready = 1'b1;
        applyStimulus(2);
        checkOutput("t6_stale_b", 128'(axi.bvalid), 128'(0));
        checkOutput("t6_stale_r", 128'(axi.rvalid), 128'(0));
        idleBus();

        // Reset discards a held W: a lone AW afterwards must not commit
        axi.wdata = 32'h7777_7777; axi.wvalid = 1'b1;
        applyStimulus(1);
        checkOutput("t7_wheld", 128'(axi.wready), 128'(0));
        axi.wvalid = 1'b0;
        areset = 1'b1;
        applyStimulus(1);
        areset = 1'b0;
        checkOutput("t7_wready", 128'(axi.wready), 128'(1));
        axi.awaddr = 32'h0; axi.awvalid = 1'b1;
        applyStimulus(1);
        axi.awvalid = 1'b0;
        checkOutput("t7_no_commit", 128'(axi.bvalid), 128'(0));
        checkOutput("t7_ctrl",      ctrl_o,           128'(0));
        applyStimulus(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axil_reg_slave.md
Name: axil_reg_slave

Overview:
- AXI-lite responder (slave end of the `Axi` interface) that exposes a bank of 32-bit control registers (RW) and status registers (RO) to a software master.
- Sits between the interconnect and the accelerator core: `ctrl_o` drives the core, `stat_i` samples it.
- Single outstanding write and single outstanding read; the AW and W channels are accepted independently, in either order.

Parameters:
- NUM_CTRL, 4, number of RW control registers at word indices 0..NUM_CTRL-1
- NUM_STAT, 4, number of RO status registers at word indices NUM_CTRL..NUM_CTRL+NUM_STAT-1
- IDX_W, 4, word-index width decoded from the address bits [IDX_W+1:2]; must satisfy 2**IDX_W >= NUM_CTRL+NUM_STAT

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- awaddr  in  32  write address
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  32  write data
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bvalid  out  1  write response valid
- bresp  out  1  response: 0 = OKAY, 1 = error
- bready  in  1  write response ready
- araddr  in  32  read address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  32  read data
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- ctrl_o  out  NUM_CTRL*32  control registers; register k occupies bits [32k+31:32k]
- stat_i  in  NUM_STAT*32  status inputs, sampled on read

Behaviour:
- Clock and reset: one clock, aclk. areset is synchronous and active-high.
- Reset values: awready=1, wready=1, arready=1, bvalid=0, bresp=0, rvalid=0, rdata=0, ctrl_o=0. All internal held flags are cleared.
- Reset mid-transaction: any pending AW/W capture, B response or R data is discarded. No response is issued for it.
- Write FSM, states W_IDLE and W_RESP:
  - W_IDLE: awready=!aw_held and wready=!w_held. Each handshake latches its payload and sets its held flag.
  - Commit happens on the edge where the second of the two handshakes completes. This may be the same edge as the first, if both complete in one cycle.
  - On commit: if idx < NUM_CTRL, the ctrl register is written and bresp=0. Otherwise no state changes and bresp=1; this covers status-register writes and out-of-range indices.
  - Same edge: both held flags clear, bvalid goes to 1 and the FSM moves to W_RESP. The updated ctrl_o and bvalid become visible in the same cycle.
  - W_RESP: awready=wready=0. Hold bvalid and bresp stable until bready. On the bvalid&bready edge, return to W_IDLE with bvalid=0.
  - Best-case latency: AW+W accepted in cycle t, bvalid in cycle t+1. Best-case throughput is one write per 2 cycles.
- Read FSM, states R_IDLE and R_DATA:
  - R_IDLE: arready=1. On arvalid&arready, rdata is registered from the decoded source and the FSM moves to R_DATA with rvalid=1 the next cycle.
  - Read sources: idx < NUM_CTRL returns ctrl; the status range returns stat_i sampled at the AR-handshake edge; out of range returns 32'h0. No rresp exists on this interface, so out-of-range reads are silent.
  - R_DATA: arready=0. Hold rdata and rvalid stable until rready, then return to R_IDLE.
- Address decode:
  - Bits [1:0] are ignored.
  - Bits [31:IDX_W+2] must be zero. Otherwise the access is out of range.
- Simultaneous events:
  - A read and a write commit to the same ctrl register on the same edge: the read returns the pre-write value.
  - The read and write paths are fully independent, with no mutual stalling.

Optional Feature:
- Macro: AXIL_REG_SLAVE_WPULSE_EN.
- Defined: adds output `wr_pulse_o`, width NUM_CTRL. Bit k is high for exactly the one cycle after a successful commit to ctrl register k, coincident with the first bvalid cycle. Error writes produce no pulse. Reset value is 0.
- Undefined: the port does not exist and all other behaviour is identical.

Decomposition:
- Package `axil_pkg` holds:
  - the response constants AXIL_OKAY=1'b0 and AXIL_ERR=1'b1;
  - the enums wr_state_t {W_IDLE, W_RESP} and rd_state_t {R_IDLE, R_DATA};
  - the localparam DATA_W=32.
- One natural sub-module, `axil_addr_dec`, which is combinational. It maps a 32-bit address to {idx, is_ctrl, is_stat, in_range} and is instantiated twice, once for AW and once for AR.

Test Plan:
- AW and W in the same cycle, addr 0x4, data 0xA5A5_0001 -> bvalid next cycle, bresp=0, ctrl_o[63:32]=0xA5A5_0001; read 0x4 returns 0xA5A5_0001.
- W presented 3 cycles before AW, addr 0x8 -> wready drops after the W handshake, and commit plus bvalid follow the AW handshake by one cycle.
- Write to addr 0x10 (status) and to 0x40 (out of range) -> bresp=1 both times and ctrl_o unchanged; read 0x40 returns 0x0.
- stat_i[31:0]=0x1234_5678, read addr 0x10 with rready held low for 4 cycles -> rvalid and rdata=0x1234_5678 held stable, arready=0 until the rready handshake.
- Same-edge write 0xFFFF_FFFF and read of addr 0x0, with prior value 0x0 -> rdata=0x0, ctrl_o[31:0]=0xFFFF_FFFF afterwards; with WPULSE_EN, wr_pulse_o=4'b0001 for one cycle.
- Assert areset while bvalid=1 and rvalid=1 -> next cycle bvalid=rvalid=0, ctrl_o=0, all ready outputs=1, and no stale response after reset.
